// File: rtl/noc_pkg.sv
// Shared types and constants for the mesh router output arbitration slice.
// Imported by the arbiter, its round-robin picker and the interface.
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int FLIT_W     = 32;
  localparam int PORT_IDX_W = 3;

  // Fixed input order of every router output arbiter.
  typedef enum logic [PORT_IDX_W-1:0] {
    PORT_N  = 3'd0,
    PORT_S  = 3'd1,
    PORT_E  = 3'd2,
    PORT_W  = 3'd3,
    PORT_PE = 3'd4
  } port_e;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [FLIT_W-1:0] payload;
    logic              tail;
  } flit_t;

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Flit handshake bundle between the router input ports, one output arbiter
// and the downstream link or PE.
interface noc_output_arbiter_if
  import noc_pkg::*;
#(
  parameter int FLIT_W    = noc_pkg::FLIT_W,
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS
);

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*FLIT_W-1:0] in_flit;
  logic [NUM_PORTS-1:0]        in_tail;
  logic [NUM_PORTS-1:0]        in_ready;
  logic                        out_valid;
  logic [FLIT_W-1:0]           out_flit;
  logic                        out_tail;
  logic [PORT_IDX_W-1:0]       out_src;
  logic                        out_ready;
  logic                        busy;

  // Upstream ports plus downstream sink, seen from outside the arbiter.
  modport master (
    output in_valid, in_flit, in_tail, out_ready,
    input  in_ready, out_valid, out_flit, out_tail, out_src, busy
  );

  // The arbiter itself.
  modport slave (
    input  in_valid, in_flit, in_tail, out_ready,
    output in_ready, out_valid, out_flit, out_tail, out_src, busy
  );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping.
// Kept free of state so the VC allocator can reuse it.
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int IDX_W     = noc_pkg::PORT_IDX_W
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_req
);

  logic [IDX_W-1:0]     cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] hit;

  // cand[gi] is the port examined at search distance gi+1 from rr_ptr.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
    assign cand[gi] = IDX_W'((32'(rr_ptr) + gi + 1) % NUM_PORTS);
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    grant = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (hit[k]) grant = cand[k];
    end
  end

  assign any_req = |hit;

endmodule

// File: rtl/noc_output_arbiter.sv
// One router output: round-robin grant locked for a whole wormhole packet,
// feeding a single registered output stage with valid/ready toward the link.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int FLIT_W    = noc_pkg::FLIT_W,
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS
) (
  input  logic           clk,
  input  logic           reset,
  noc_output_arbiter_if.slave bus
);

  localparam int IDX_W = PORT_IDX_W;

  arb_state_e        state_reg;
  logic [IDX_W-1:0]  grant_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic              busy_reg;
  logic              out_valid_reg;
  logic [FLIT_W-1:0] out_flit_reg;
  logic              out_tail_reg;
  logic [IDX_W-1:0]  out_src_reg;

  logic [IDX_W-1:0]  pick;
  logic              any_req;
  logic              locked;
  logic              stage_free;
  logic              grant_valid;
  logic              grant_tail;
  logic [FLIT_W-1:0] grant_flit;
  logic              xfer;

  noc_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req     (bus.in_valid),
    .rr_ptr  (rr_ptr_reg),
    .grant   (pick),
    .any_req (any_req)
  );

  assign locked      = (state_reg == ST_LOCKED);
  // The stage can take a flit if empty or if its current flit leaves this cycle.
  assign stage_free  = !out_valid_reg || bus.out_ready;
  assign grant_valid = bus.in_valid[grant_reg];
  assign grant_tail  = bus.in_tail[grant_reg];
  assign grant_flit  = bus.in_flit[32'(grant_reg) * FLIT_W +: FLIT_W];
  assign xfer        = locked && grant_valid && stage_free;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
    assign bus.in_ready[gi] = !reset && locked && stage_free &&
                              (grant_reg == IDX_W'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= IDX_W'(NUM_PORTS - 1);
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
      out_tail_reg  <= 1'b0;
      out_src_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            grant_reg <= pick;
            state_reg <= ST_LOCKED;
            busy_reg  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          // Lock is released only by an accepted tail; a stalled sender keeps it.
          if (xfer && grant_tail) begin
            rr_ptr_reg <= grant_reg;
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_flit_reg  <= grant_flit;
        out_tail_reg  <= grant_tail;
        out_src_reg   <= grant_reg;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_flit  = out_flit_reg;
  assign bus.out_tail  = out_tail_reg;
  assign bus.out_src   = out_src_reg;
  assign bus.busy      = busy_reg;

endmodule
